// File: rtl/fp_mac_pkg.sv
// Shared constants, FSM encoding and register-command bundle for the FP MAC sequencer.
package fp_mac_pkg;

    // Register map
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_LEN    = 3'd1;
    localparam logic [2:0] ADDR_ACC    = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_COUNT  = 3'd4;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    // IEEE-754 single constants
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Decoded one-cycle commands from the register file to the sequencer
    typedef struct packed {
        logic        start;
        logic        abort;
        logic        acc_wr;
        logic        status_rd;
        logic [31:0] wdata;
    } reg_cmd_t;

endpackage

// File: rtl/fp_mac_sequencer_if.sv
// Avalon-MM slave bus bundle for the FP MAC sequencer.
interface fp_mac_sequencer_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output chipselect, address, write, writedata, read,
        input  readdata
    );

    modport slave (
        input  chipselect, address, write, writedata, read,
        output readdata
    );
endinterface

// File: rtl/fp_mac_seq_regs.sv
// Avalon register file: LEN / irq_en storage, command decode and registered read mux.
module fp_mac_seq_regs
    import fp_mac_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    fp_mac_sequencer_if.slave bus,
    input  logic              busy,
    input  logic              done,
    input  logic              aborted,
    input  logic [31:0]       acc,
    input  logic [LEN_W-1:0]  count,
    output logic [LEN_W-1:0]  len,
    output logic              irq_en,
    output reg_cmd_t          cmd
);

    logic        wr_hit;
    logic        rd_hit;
    logic [31:0] rd_mux;

    assign wr_hit = bus.chipselect & bus.write;
    assign rd_hit = bus.chipselect & bus.read;

    // Decode write pulses and the status read (which clears sticky flags).
    always_comb begin
        cmd           = '0;
        cmd.wdata     = bus.writedata;
        cmd.start     = wr_hit && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_START];
        cmd.abort     = wr_hit && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_ABORT];
        cmd.acc_wr    = wr_hit && (bus.address == ADDR_ACC);
        cmd.status_rd = rd_hit && (bus.address == ADDR_STATUS);
    end

    // Read mux; CTRL is write-only and unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_LEN:    rd_mux = 32'(len);
            ADDR_ACC:    rd_mux = acc;
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY]    = busy;
                rd_mux[STAT_DONE]    = done;
                rd_mux[STAT_ABORTED] = aborted;
            end
            ADDR_COUNT:  rd_mux = 32'(count);
            default:     rd_mux = '0;
        endcase
    end

    // LEN is frozen while a job runs; irq_en follows every CTRL write.
    always_ff @(posedge clk) begin
        if (reset) begin
            len          <= '0;
            irq_en       <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_hit && (bus.address == ADDR_CTRL))
                irq_en <= bus.writedata[CTRL_IRQ_EN];
            if (wr_hit && (bus.address == ADDR_LEN) && !busy)
                len <= bus.writedata[LEN_W-1:0];
            if (rd_hit)
                bus.readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/fp_mac_sequencer.sv
// Dot-product sequencer: pops operand pairs from two buffers and issues one MAC per pair.
module fp_mac_sequencer
    import fp_mac_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    fp_mac_sequencer_if.slave bus,
    output logic              irq,
    output logic              bufa_rd_en,
    input  logic [31:0]       bufa_rd_data,
    input  logic              bufa_empty,
    output logic              bufb_rd_en,
    input  logic [31:0]       bufb_rd_data,
    input  logic              bufb_empty,
    output logic              mac_start,
    output logic [31:0]       mac_op_a,
    output logic [31:0]       mac_op_b,
    output logic [31:0]       mac_acc,
    input  logic              mac_done,
    input  logic [31:0]       mac_result
);

    state_t             state, state_nxt;
    reg_cmd_t           cmd;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   count_inc;
    logic [31:0]        acc;
    logic               irq_en;
    logic               done;
    logic               aborted;
    logic               abort_pend;   // abort seen while a MAC is in flight
    logic               busy;

    assign count_inc = count + 1'b1;
    assign busy      = (state == S_FETCH) || (state == S_LOAD) ||
                       (state == S_ISSUE) || (state == S_WAIT);
    assign irq       = done & irq_en;

    fp_mac_seq_regs #(.LEN_W(LEN_W)) u_regs (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .acc     (acc),
        .count   (count),
        .len     (len),
        .irq_en  (irq_en),
        .cmd     (cmd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and the combinational pop/issue strobes.
    always_comb begin
        state_nxt  = state;
        bufa_rd_en = 1'b0;
        bufb_rd_en = 1'b0;
        mac_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd.start && !cmd.abort)
                    state_nxt = (len == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                if (cmd.abort) begin
                    state_nxt = S_IDLE;
                end else if (!bufa_empty && !bufb_empty) begin
                    bufa_rd_en = 1'b1;
                    bufb_rd_en = 1'b1;
                    state_nxt  = S_LOAD;
                end
            end
            S_LOAD:  state_nxt = cmd.abort ? S_IDLE : S_ISSUE;
            S_ISSUE: begin
                mac_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mac_done) begin
                    if (abort_pend || cmd.abort) state_nxt = S_IDLE;
                    else if (count_inc == len)   state_nxt = S_DONE;
                    else                         state_nxt = S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, accumulator, element count and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= FP_ZERO;
            count      <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            mac_op_a   <= FP_ZERO;
            mac_op_b   <= FP_ZERO;
            mac_acc    <= FP_ZERO;
        end else begin
            if (cmd.status_rd) begin
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            if (cmd.acc_wr && !busy)
                acc <= cmd.wdata;
            case (state)
                S_IDLE: begin
                    if (cmd.start && !cmd.abort && (len != '0)) begin
                        count      <= '0;
                        abort_pend <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (cmd.abort) aborted <= 1'b1;
                end
                S_LOAD: begin
                    if (cmd.abort) begin
                        aborted <= 1'b1;
                    end else begin
                        mac_op_a <= bufa_rd_data;
                        mac_op_b <= bufb_rd_data;
                        mac_acc  <= acc;
                    end
                end
                S_ISSUE: begin
                    if (cmd.abort) abort_pend <= 1'b1;
                end
                S_WAIT: begin
                    if (mac_done) begin
                        acc   <= mac_result;
                        count <= count_inc;
                        if (abort_pend || cmd.abort) begin
                            aborted    <= 1'b1;
                            abort_pend <= 1'b0;
                        end
                    end else if (cmd.abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                S_DONE:  done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Directed bench: buffer and MAC stubs, table of dot-product jobs plus corner-case sequences.
module tb_fp_mac_sequencer;
    import fp_mac_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq;
    logic        bufa_rd_en, bufb_rd_en;
    logic [31:0] bufa_rd_data = '0, bufb_rd_data = '0;
    logic        bufa_empty, bufb_empty;
    logic        mac_start;
    logic [31:0] mac_op_a, mac_op_b, mac_acc;
    logic        mac_done = 1'b0;
    logic [31:0] mac_result = '0;

    fp_mac_sequencer_if bus();

    fp_mac_sequencer #(.LEN_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .irq          (irq),
        .bufa_rd_en   (bufa_rd_en),
        .bufa_rd_data (bufa_rd_data),
        .bufa_empty   (bufa_empty),
        .bufb_rd_en   (bufb_rd_en),
        .bufb_rd_data (bufb_rd_data),
        .bufb_empty   (bufb_empty),
        .mac_start    (mac_start),
        .mac_op_a     (mac_op_a),
        .mac_op_b     (mac_op_b),
        .mac_acc      (mac_acc),
        .mac_done     (mac_done),
        .mac_result   (mac_result)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // ---------------- buffer model ----------------
    logic [31:0] amem [64];
    logic [31:0] bmem [64];
    int a_wp = 0, a_rp = 0, b_wp = 0, b_rp = 0;
    bit popa_pend = 0, popb_pend = 0;
    int bad_pops = 0;

    assign bufa_empty = (a_wp == a_rp);
    assign bufb_empty = (b_wp == b_rp);

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        amem[a_wp % 64] = a; a_wp++;
        bmem[b_wp % 64] = b; b_wp++;
    endtask

    // Data and empty flag update the cycle after a pop request.
    always @(negedge clk) begin
        if (popa_pend) begin bufa_rd_data = amem[a_rp % 64]; a_rp++; popa_pend = 0; end
        if (popb_pend) begin bufb_rd_data = bmem[b_rp % 64]; b_rp++; popb_pend = 0; end
        if (bufa_rd_en) begin if (bufa_empty) bad_pops++; popa_pend = 1; end
        if (bufb_rd_en) begin if (bufb_empty) bad_pops++; popb_pend = 1; end
    end

    // ---------------- MAC stub ----------------
    int          n_start = 0;
    logic [31:0] log_a [32];
    logic [31:0] log_b [32];
    logic [31:0] log_c [32];
    logic [31:0] exp_res [32];
    int          mac_lat = 2;
    int          mcnt = 0;
    bit          mpend = 0;
    logic [31:0] mres = '0;
    int          force_req = 0, force_ack = 0;

    always @(negedge clk) begin
        mac_done = 1'b0;
        if (mpend) begin
            if (mcnt == 0) begin mac_done = 1'b1; mac_result = mres; mpend = 0; end
            else mcnt--;
        end else if (force_req != force_ack) begin
            mac_done   = 1'b1;
            mac_result = 32'h1234_5678;
            force_ack  = force_req;
        end
        if (mac_start) begin
            log_a[n_start % 32] = mac_op_a;
            log_b[n_start % 32] = mac_op_b;
            log_c[n_start % 32] = mac_acc;
            mres  = exp_res[n_start % 32];
            mcnt  = mac_lat;
            mpend = 1;
            n_start++;
        end
    end

    // ---------------- bus helpers ----------------
    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(nm, d, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_starts(input int target, input string nm);
        for (int i = 0; i < 300; i++) begin
            if (n_start >= target) break;
            @(negedge clk);
        end
        chk(nm, 32'(n_start >= target), 32'd1);
    endtask

    // ---------------- job table ----------------
    typedef struct packed {
        int               len;
        logic [31:0]      acc0;
        int               npairs;
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][31:0] res;
        logic [31:0]      exp_acc;
        int               exp_cnt;
        logic [31:0]      exp_stat;
        int               w;
    } vec_t;

    vec_t vecs [4];
    int   n_exp = 0;

    initial begin
        int base_s, base_a, base_b;
        vec_t v;

        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0;

        // element 0 sits in the low word of each packed array
        vecs[0] = '{len:0, acc0:FP_ONE, npairs:0, a:'0, b:'0, res:'0,
                    exp_acc:FP_ONE, exp_cnt:0, exp_stat:32'h2, w:1};
        vecs[1] = '{len:2, acc0:FP_ZERO, npairs:2,
                    a:{32'h0, 32'h0, 32'h4040_0000, 32'h3F80_0000},
                    b:{32'h0, 32'h0, 32'h4080_0000, 32'h4000_0000},
                    res:{32'h0, 32'h0, 32'h4160_0000, 32'h4000_0000},
                    exp_acc:32'h4160_0000, exp_cnt:2, exp_stat:32'h2, w:40};
        vecs[2] = '{len:1, acc0:32'hFF80_0000, npairs:1,
                    a:{32'h0, 32'h0, 32'h0, 32'h7FC0_0000},
                    b:{32'h0, 32'h0, 32'h0, FP_ONE},
                    res:{32'h0, 32'h0, 32'h0, 32'h7FC0_0000},
                    exp_acc:32'h7FC0_0000, exp_cnt:1, exp_stat:32'h2, w:20};
        vecs[3] = '{len:3, acc0:FP_ONE, npairs:3,
                    a:{32'h0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000},
                    b:{32'h0, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000},
                    res:{32'h0, 32'h4150_0000, 32'h4110_0000, 32'h40A0_0000},
                    exp_acc:32'h4150_0000, exp_cnt:3, exp_stat:32'h2, w:40};

        // ---- reset state ----
        wait_cycles(3);
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_rda", {31'b0, bufa_rd_en}, 32'h0);
        chk("rst_rdb", {31'b0, bufb_rd_en}, 32'h0);
        chk("rst_mac_start", {31'b0, mac_start}, 32'h0);
        chk("rst_op_a", mac_op_a, 32'h0);
        chk("rst_op_b", mac_op_b, 32'h0);
        chk("rst_mac_acc", mac_acc, 32'h0);
        reset = 1'b0;
        rd_chk("rst_status", ADDR_STATUS, 32'h0);
        rd_chk("rst_acc", ADDR_ACC, 32'h0);
        rd_chk("rst_len", ADDR_LEN, 32'h0);
        rd_chk("unmapped", 3'd6, 32'h0);

        // ---- table-driven jobs ----
        for (int k = 0; k < 4; k++) begin
            v = vecs[k];
            bus_wr(ADDR_LEN, 32'(v.len));
            bus_wr(ADDR_ACC, v.acc0);
            for (int i = 0; i < v.npairs; i++) push(v.a[i], v.b[i]);
            for (int i = 0; i < v.len; i++) exp_res[(n_exp + i) % 32] = v.res[i];
            base_s = n_start; base_a = a_rp; base_b = b_rp;
            bus_wr(ADDR_CTRL, 32'h5);
            wait_cycles(v.w);
            chk($sformatf("v%0d_irq", k), {31'b0, irq}, 32'h1);
            rd_chk($sformatf("v%0d_acc", k), ADDR_ACC, v.exp_acc);
            rd_chk($sformatf("v%0d_count", k), ADDR_COUNT, 32'(v.exp_cnt));
            rd_chk($sformatf("v%0d_status", k), ADDR_STATUS, v.exp_stat);
            chk($sformatf("v%0d_irq_clr", k), {31'b0, irq}, 32'h0);
            chk($sformatf("v%0d_starts", k), 32'(n_start - base_s), 32'(v.len));
            chk($sformatf("v%0d_pops_a", k), 32'(a_rp - base_a), 32'(v.len));
            chk($sformatf("v%0d_pops_b", k), 32'(b_rp - base_b), 32'(v.len));
            for (int i = 0; i < v.len; i++) begin
                chk($sformatf("v%0d_op_a%0d", k, i), log_a[(n_exp + i) % 32], v.a[i]);
                chk($sformatf("v%0d_op_b%0d", k, i), log_b[(n_exp + i) % 32], v.b[i]);
                chk($sformatf("v%0d_addend%0d", k, i), log_c[(n_exp + i) % 32],
                    (i == 0) ? v.acc0 : v.res[i-1]);
            end
            n_exp += v.len;
        end

        // ---- stray mac_done while idle ----
        force_req++;
        wait_cycles(5);
        rd_chk("stray_acc", ADDR_ACC, 32'h4150_0000);
        rd_chk("stray_count", ADDR_COUNT, 32'd3);
        rd_chk("stray_status", ADDR_STATUS, 32'h0);

        // ---- stall on empty buffer, start/LEN/ACC writes while busy ----
        bus_wr(ADDR_LEN, 32'd3);
        bus_wr(ADDR_ACC, FP_ZERO);
        push(FP_ONE, FP_ONE);
        exp_res[n_exp % 32]       = 32'h3F80_0000;
        exp_res[(n_exp + 1) % 32] = 32'h4000_0000;
        exp_res[(n_exp + 2) % 32] = 32'h4040_0000;
        base_s = n_start; base_a = a_rp;
        bus_wr(ADDR_CTRL, 32'h5);
        wait_cycles(30);
        rd_chk("stall_status", ADDR_STATUS, 32'h1);
        rd_chk("stall_count", ADDR_COUNT, 32'd1);
        bus_wr(ADDR_CTRL, 32'h5);
        bus_wr(ADDR_LEN, 32'd7);
        bus_wr(ADDR_ACC, 32'hDEAD_BEEF);
        wait_cycles(5);
        rd_chk("busy_len", ADDR_LEN, 32'd3);
        push(FP_ONE, FP_ONE);
        push(FP_ONE, FP_ONE);
        wait_cycles(40);
        rd_chk("stall_acc", ADDR_ACC, 32'h4040_0000);
        rd_chk("stall_count_end", ADDR_COUNT, 32'd3);
        rd_chk("stall_status_end", ADDR_STATUS, 32'h2);
        chk("stall_addend1", log_c[(n_exp + 1) % 32], 32'h3F80_0000);
        chk("stall_pops", 32'(a_rp - base_a), 32'd3);
        chk("stall_starts", 32'(n_start - base_s), 32'd3);
        n_exp += 3;

        // ---- abort while the 2nd MAC is outstanding ----
        mac_lat = 20;
        bus_wr(ADDR_LEN, 32'd4);
        bus_wr(ADDR_ACC, FP_ZERO);
        for (int i = 0; i < 4; i++) push(FP_ONE, FP_ONE);
        exp_res[n_exp % 32]       = 32'h3F80_0000;
        exp_res[(n_exp + 1) % 32] = 32'h4000_0000;
        exp_res[(n_exp + 2) % 32] = 32'h4040_0000;
        exp_res[(n_exp + 3) % 32] = 32'h4080_0000;
        base_s = n_start; base_a = a_rp; base_b = b_rp;
        bus_wr(ADDR_CTRL, 32'h5);
        wait_starts(base_s + 2, "abort_wait_issue");
        bus_wr(ADDR_CTRL, 32'h6);
        wait_cycles(60);
        chk("abort_irq", {31'b0, irq}, 32'h0);
        rd_chk("abort_acc", ADDR_ACC, 32'h4000_0000);
        rd_chk("abort_count", ADDR_COUNT, 32'd2);
        rd_chk("abort_status", ADDR_STATUS, 32'h4);
        chk("abort_pops_a", 32'(a_rp - base_a), 32'd2);
        chk("abort_pops_b", 32'(b_rp - base_b), 32'd2);
        chk("abort_starts", 32'(n_start - base_s), 32'd2);
        n_exp += 2;

        // ---- abort and start in one write: abort wins ----
        base_a = a_rp;
        bus_wr(ADDR_CTRL, 32'h7);
        wait_cycles(10);
        rd_chk("abst_status", ADDR_STATUS, 32'h0);
        chk("abst_pops", 32'(a_rp - base_a), 32'd0);

        // ---- reset mid-WAIT, then a stray mac_done ----
        bus_wr(ADDR_ACC, FP_ONE);
        bus_wr(ADDR_LEN, 32'd1);
        rd_chk("pre_rst_len", ADDR_LEN, 32'd1);
        exp_res[n_exp % 32] = 32'h4040_0000;
        base_s = n_start;
        bus_wr(ADDR_CTRL, 32'h5);
        wait_starts(base_s + 1, "rst_wait_issue");
        wait_cycles(2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_mac_start", {31'b0, mac_start}, 32'h0);
        chk("mid_rst_rda", {31'b0, bufa_rd_en}, 32'h0);
        chk("mid_rst_rdb", {31'b0, bufb_rd_en}, 32'h0);
        chk("mid_rst_op_a", mac_op_a, 32'h0);
        chk("mid_rst_op_b", mac_op_b, 32'h0);
        chk("mid_rst_mac_acc", mac_acc, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_readdata", bus.readdata, 32'h0);
        reset = 1'b0;
        wait_cycles(40);
        rd_chk("post_rst_acc", ADDR_ACC, 32'h0);
        rd_chk("post_rst_count", ADDR_COUNT, 32'h0);
        rd_chk("post_rst_status", ADDR_STATUS, 32'h0);
        rd_chk("post_rst_len", ADDR_LEN, 32'h0);

        chk("no_empty_pops", 32'(bad_pops), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mac_sequencer.md
Name: fp_mac_sequencer

Overview:
Avalon-MM-controlled sequencer that computes a dot product using the FP MAC datapath and two operand data buffers. Software preloads buffer A and buffer B, writes a vector length and an initial accumulator value, then starts the job. The block pops one operand pair per step and issues one MAC operation (acc = a*b + acc) per pair. It holds the running sum and raises done/irq when the job finishes.

Parameters:
LEN_W, 8, width of the vector-length and element-count registers (maximum length 2^LEN_W-1)

Ports:
clk  in  1  system clock (Avalon bus clock)
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
address  in  3  Avalon register address
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
read  in  1  Avalon read strobe
readdata  out  32  registered read data
irq  out  1  level interrupt, equal to done & irq_en
bufa_rd_en  out  1  pop request to buffer A
bufa_rd_data  in  32  buffer A data, valid the cycle after bufa_rd_en
bufa_empty  in  1  buffer A empty flag
bufb_rd_en  out  1  pop request to buffer B
bufb_rd_data  in  32  buffer B data, valid the cycle after bufb_rd_en
bufb_empty  in  1  buffer B empty flag
mac_start  out  1  one-cycle MAC issue pulse
mac_op_a  out  32  multiplier operand A (IEEE-754 single)
mac_op_b  out  32  multiplier operand B
mac_acc  out  32  addend (current accumulator)
mac_done  in  1  one-cycle pulse; mac_result is valid in the same cycle
mac_result  in  32  a*b + acc

Behaviour:
Register map (all accesses require chipselect):
- Address 0, CTRL, write-only pulses:
  - bit0 start
  - bit1 abort
  - bit2 irq_en (this bit is sticky)
- Address 1, LEN: read/write, LEN_W bits, zero-extended.
- Address 2, ACC: write loads the accumulator (ignored while busy); read returns the accumulator.
- Address 3, STATUS, read:
  - bit0 busy
  - bit1 done
  - bit2 aborted
- Address 4, COUNT, read: number of completed elements.
- Reading address 3 clears done and aborted.
- Unmapped addresses read 0.
- readdata is updated on the clock edge after a read and holds its value otherwise.

Reset values: readdata, irq, bufa_rd_en, bufb_rd_en, mac_start, mac_op_a, mac_op_b and mac_acc = 0. Accumulator, LEN, COUNT, irq_en and all flags = 0. State = IDLE.

FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, DONE.
- IDLE: on start with LEN==0, go to DONE with no pops. On start with LEN>0, clear COUNT, set busy, go to FETCH.
- FETCH: stall while either buffer is empty. When both are non-empty, assert bufa_rd_en and bufb_rd_en together for exactly one cycle, then go to LOAD.
- LOAD: capture bufa_rd_data and bufb_rd_data into mac_op_a and mac_op_b, and the accumulator into mac_acc. Go to ISSUE.
- ISSUE: mac_start=1 for one cycle. Go to WAIT.
- WAIT: on mac_done, accumulator <= mac_result and COUNT <= COUNT+1. If the new COUNT==LEN go to DONE, else go to FETCH.
- DONE: clear busy, set done, go to IDLE.

Latency: minimum of 4 cycles plus the MAC latency per element; no overlap between elements.

Boundary conditions:
- start while busy: ignored.
- Writes to LEN while busy: ignored.
- abort in FETCH or LOAD: return to IDLE immediately, set aborted, no further pops.
- abort in ISSUE or WAIT: the block completes the outstanding MAC (the result is written to the accumulator), then goes to IDLE with aborted set.
- abort and start in the same write: abort wins.
- mac_done outside WAIT: ignored.
- A buffer empty mid-job: stall indefinitely in FETCH; busy stays 1.
- Never pop a buffer that is empty.
- COUNT does not wrap, because it is bounded by LEN.
- Reset mid-job: returns all state to reset values; a later stray mac_done is ignored.
- The block does no FP arithmetic itself; special values (NaN, inf, 0) pass through unchanged.

Decomposition:
- A shared package (fp_mac_pkg) holds:
  - register address constants (ADDR_CTRL=0, ADDR_LEN=1, ADDR_ACC=2, ADDR_STATUS=3, ADDR_COUNT=4);
  - CTRL and STATUS bit indices;
  - the FSM state encoding;
  - FP constants (FP_ZERO=32'h0, FP_ONE=32'h3F800000).
- One natural sub-module: fp_mac_seq_regs, the Avalon register file and readdata mux, kept separate from the FSM.

Test Plan:
- LEN=2, ACC=0, A={0x3F800000, 0x40400000}, B={0x40000000, 0x40800000}, start -> mac_start pulses twice; ACC reads 0x41600000 (14.0); COUNT=2; STATUS=0x2; irq=1 when irq_en is set.
- LEN=0, start -> DONE within 2 cycles; no rd_en pulses; ACC unchanged.
- LEN=3 with only 1 pair preloaded -> stalls in FETCH with busy=1; push 2 more pairs -> completes; COUNT=3.
- Abort written while waiting on the 2nd mac_done of LEN=4 -> the 2nd result is accumulated; COUNT=2; STATUS=0x4; no further pops.
- start written while busy, plus a stray mac_done in IDLE -> no state change, accumulator unchanged.
- reset asserted mid-WAIT -> all outputs 0 the next cycle; the following mac_done is ignored; ACC reads 0.
